// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared constants and types for the write-back stage
package regfile_writeback_pkg;

  localparam logic RESET = 1'b1;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - execute/memory/decode side bundle of the write-back stage
interface regfile_writeback_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  localparam int NREGS = 1 << ADDRESS_WIDTH;

  logic                     issue_valid;
  logic [ADDRESS_WIDTH-1:0] issue_id;

  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDRESS_WIDTH-1:0] alu_id;
  logic [DATA_WIDTH-1:0]    alu_data;

  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDRESS_WIDTH-1:0] mem_id;
  logic [DATA_WIDTH-1:0]    mem_data;

  logic [ADDRESS_WIDTH-1:0] read1_id;
  logic [ADDRESS_WIDTH-1:0] read2_id;
  logic                     hazard;
  logic [NREGS-1:0]         busy_mask;

  logic                     write_en;
  logic [ADDRESS_WIDTH-1:0] write_id;
  logic [DATA_WIDTH-1:0]    write_data;

  modport master (
    output issue_valid, issue_id,
    output alu_valid, alu_id, alu_data,
    input  alu_ready,
    output mem_valid, mem_id, mem_data,
    input  mem_ready,
    output read1_id, read2_id,
    input  hazard, busy_mask,
    input  write_en, write_id, write_data
  );

  modport slave (
    input  issue_valid, issue_id,
    input  alu_valid, alu_id, alu_data,
    output alu_ready,
    input  mem_valid, mem_id, mem_data,
    output mem_ready,
    input  read1_id, read2_id,
    output hazard, busy_mask,
    output write_en, write_id, write_data
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result buffer; pointers carry one wrap bit so full/empty come from a compare
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] storage_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_data = storage_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload needs no reset: it is only observed behind a valid pointer pair.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write port owner: ALU/load arbitration,
// starvation guard, pending-load scoreboard and the registered write.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave wb
);
  localparam int NREGS    = 1 << ADDRESS_WIDTH;
  localparam int ENTRY_W  = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = 1;

  logic [STARVE_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic [NREGS-1:0]         busy_q, busy_d;
  logic                     write_en_q, write_en_d;
  logic [ADDRESS_WIDTH-1:0] write_id_q, write_id_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]       fifo_head;
  logic [ADDRESS_WIDTH-1:0] pop_id;
  logic [DATA_WIDTH-1:0]    pop_data;
  logic                     forced, alu_xfer;
  wb_src_e                  src;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({wb.mem_id, wb.mem_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {pop_id, pop_data} = fifo_head;

  // Ready signals depend on state only, so no valid->ready combinational path exists.
  assign forced       = (starve_cnt_q == STARVE_MAX);
  assign wb.alu_ready = !forced;
  assign wb.mem_ready = !fifo_full;
  assign wb.hazard    = busy_q[wb.read1_id] | busy_q[wb.read2_id];
  assign wb.busy_mask = busy_q;
  assign wb.write_en   = write_en_q;
  assign wb.write_id   = write_id_q;
  assign wb.write_data = write_data_q;

  always_comb begin
    alu_xfer  = wb.alu_valid && !forced;
    fifo_push = wb.mem_valid && !fifo_full;
    fifo_pop  = !fifo_empty && (!alu_xfer || forced);
    if (fifo_pop) begin
      src = WB_MEM;
    end else if (alu_xfer) begin
      src = WB_ALU;
    end else begin
      src = WB_NONE;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + STARVE_ONE;
    end
  end

  // With no winner the id/data registers hold; only write_en is meaningful then.
  always_comb begin
    write_en_d   = 1'b0;
    write_id_d   = write_id_q;
    write_data_d = write_data_q;
    unique case (src)
      WB_ALU: begin
        write_en_d   = (wb.alu_id != '0);
        write_id_d   = wb.alu_id;
        write_data_d = wb.alu_data;
      end
      WB_MEM: begin
        write_en_d   = (pop_id != '0);
        write_id_d   = pop_id;
        write_data_d = pop_data;
      end
      default: ;
    endcase
  end

  // Clear before set so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) begin
      busy_d[pop_id] = 1'b0;
    end
    if (wb.issue_valid && (wb.issue_id != '0)) begin
      busy_d[wb.issue_id] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET) begin
      starve_cnt_q <= '0;
      busy_q       <= '0;
      write_en_q   <= 1'b0;
      write_id_q   <= '0;
      write_data_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      write_en_q   <= write_en_d;
      write_id_q   <= write_id_d;
      write_data_q <= write_data_d;
    end
  end

  // Upstream contract: decode and the ALU never touch a busy register; loads follow an issue.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
    (wb.issue_valid && (wb.issue_id != '0)) |-> !busy_q[wb.issue_id]);
  a_alu_not_busy: assert property (@(posedge clk) disable iff (rst)
    (alu_xfer && (wb.alu_id != '0)) |-> !busy_q[wb.alu_id]);
  a_mem_was_issued: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> ((wb.mem_id == '0) || busy_q[wb.mem_id]));

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed scenarios plus randomized traffic against a queue model
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int AW = 5, DW = 32, DEPTH = 4, LIMIT = 4, NREGS = 32;

  typedef struct packed {
    logic [AW-1:0] id;
    logic [DW-1:0] data;
  } load_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regfile_writeback_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_writeback #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  load_t          m_fifo[$];
  int             m_starve;
  logic [NREGS-1:0] m_busy;
  logic           m_we;
  logic [AW-1:0]  m_wid;
  logic [DW-1:0]  m_wdata;
  wb_src_e        m_src;

  task automatic model_reset();
    m_fifo.delete();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_wid    = '0;
    m_wdata  = '0;
  endtask

  // One clock of the write-back rules applied to queue/array state.
  task automatic model_edge();
    bit    forced_now, alu_go, push, pop;
    int    occupancy;
    load_t head;
    occupancy  = m_fifo.size();
    forced_now = (m_starve == LIMIT);
    alu_go     = bus.alu_valid && !forced_now;
    push       = bus.mem_valid && (occupancy < DEPTH);
    pop        = (occupancy > 0) && (!alu_go || forced_now);
    m_src      = pop ? WB_MEM : (alu_go ? WB_ALU : WB_NONE);
    m_we       = 1'b0;
    if (m_src == WB_MEM) begin
      head = m_fifo.pop_front();
      m_we = (head.id != 0); m_wid = head.id; m_wdata = head.data;
      m_busy[head.id] = 1'b0;
    end else if (m_src == WB_ALU) begin
      m_we = (bus.alu_id != 0); m_wid = bus.alu_id; m_wdata = bus.alu_data;
    end
    if (occupancy == 0 || pop) m_starve = 0;
    else if (m_starve < LIMIT) m_starve = m_starve + 1;
    if (bus.issue_valid && bus.issue_id != 0) m_busy[bus.issue_id] = 1'b1;
    m_busy[0] = 1'b0;
    if (push) m_fifo.push_back('{id: bus.mem_id, data: bus.mem_data});
  endtask

  task automatic step_cycle();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.issue_id = '0;
    bus.alu_valid   = 1'b0; bus.alu_id   = '0; bus.alu_data = '0;
    bus.mem_valid   = 1'b0; bus.mem_id   = '0; bus.mem_data = '0;
    bus.read1_id    = '0;   bus.read2_id = '0;
  endtask

  task automatic issue(input logic [AW-1:0] id);
    drive_idle();
    bus.issue_valid = 1'b1; bus.issue_id = id;
    step_cycle();
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_id = 5'd5; bus.alu_data = 32'hCAFE_F00D;
    bus.mem_valid = 1'b1; bus.mem_id = 5'd0; bus.mem_data = 32'h1;
    repeat (3) step_cycle();
    checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en: got %0h expected 0", bus.write_en); end
    checks++; if (bus.write_id !== '0 || bus.write_data !== '0) begin failures++; $display("FAIL reset_write_regs: got %0h/%0h expected 0/0", bus.write_id, bus.write_data); end
    checks++; if (bus.busy_mask !== '0) begin failures++; $display("FAIL reset_busy: got %0h expected 0", bus.busy_mask); end
    checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got alu=%0b mem=%0b expected 1/1", bus.alu_ready, bus.mem_ready); end
    drive_idle();
    rst = 1'b0;
    step_cycle();
    // The id-0 load offered during reset must not have been captured.
    checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL reset_ignored_inputs: got write_en %0b expected 0", bus.write_en); end
  endtask

  task automatic test_alu_only();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_id = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready: got %0b expected 1", bus.alu_ready); end
    step_cycle();
    drive_idle();
    checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL alu_write: got en=%0b id=%0d data=%0h expected 1/5/deadbeef", bus.write_en, bus.write_id, bus.write_data); end
    step_cycle();
    checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL alu_write_drop: got %0b expected 0", bus.write_en); end
  endtask

  task automatic test_load_round_trip();
    issue(5'd7);
    bus.read1_id = 5'd7; bus.read2_id = 5'd2;
    #1;
    checks++; if (bus.busy_mask[7] !== 1'b1 || bus.hazard !== 1'b1) begin
      failures++; $display("FAIL load_busy_set: got busy=%0b hazard=%0b expected 1/1", bus.busy_mask[7], bus.hazard); end
    step_cycle(); step_cycle();
    bus.mem_valid = 1'b1; bus.mem_id = 5'd7; bus.mem_data = 32'h1234;
    step_cycle();
    bus.mem_valid = 1'b0;
    #1;
    checks++; if (bus.write_en !== 1'b0 || bus.busy_mask[7] !== 1'b1) begin
      failures++; $display("FAIL load_early: got en=%0b busy=%0b expected 0/1", bus.write_en, bus.busy_mask[7]); end
    step_cycle();
    checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, 5'd7, 32'h1234}) begin
      failures++; $display("FAIL load_write: got en=%0b id=%0d data=%0h expected 1/7/1234", bus.write_en, bus.write_id, bus.write_data); end
    checks++; if (bus.busy_mask[7] !== 1'b0 || bus.hazard !== 1'b0) begin
      failures++; $display("FAIL load_busy_clear: got busy=%0b hazard=%0b expected 0/0", bus.busy_mask[7], bus.hazard); end
    drive_idle();
  endtask

  task automatic test_starvation();
    logic [DW-1:0] d;
    issue(5'd10);
    bus.mem_valid = 1'b1; bus.mem_id = 5'd10; bus.mem_data = 32'hA5A5_0010;
    bus.alu_valid = 1'b1; bus.alu_id = 5'd1; bus.alu_data = $urandom;
    step_cycle();
    bus.mem_valid = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      d = $urandom;
      bus.alu_id = AW'(k + 2); bus.alu_data = d;
      #1;
      checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL starve_alu_ready[%0d]: got %0b expected 1", k, bus.alu_ready); end
      step_cycle();
      checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, AW'(k + 2), d}) begin
        failures++; $display("FAIL starve_alu_write[%0d]: got id=%0d data=%0h expected %0d/%0h", k, bus.write_id, bus.write_data, k + 2, d); end
    end
    d = $urandom;
    bus.alu_id = 5'd6; bus.alu_data = d;
    #1;
    checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL starve_forced: got alu_ready %0b expected 0", bus.alu_ready); end
    step_cycle();
    checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, 5'd10, 32'hA5A5_0010}) begin
      failures++; $display("FAIL starve_fifo_write: got id=%0d data=%0h expected 10/a5a50010", bus.write_id, bus.write_data); end
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL starve_resume_ready: got %0b expected 1", bus.alu_ready); end
    step_cycle();
    checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, 5'd6, d}) begin
      failures++; $display("FAIL starve_resume_write: got id=%0d data=%0h expected 6/%0h", bus.write_id, bus.write_data, d); end
    drive_idle();
    step_cycle();
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 5; i++) issue(AW'(11 + i));
    bus.alu_valid = 1'b1; bus.alu_id = 5'd20; bus.alu_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1; bus.mem_id = AW'(11 + i); bus.mem_data = 32'hF000_0000 + i;
      #1;
      checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL full_push_ready[%0d]: got %0b expected 1", i, bus.mem_ready); end
      step_cycle();
    end
    bus.mem_id = 5'd15; bus.mem_data = 32'hF000_0004;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low: got %0b expected 0", bus.mem_ready); end
    step_cycle();
    checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
      failures++; $display("FAIL full_forced_pop: got mem_ready=%0b alu_ready=%0b expected 0/0", bus.mem_ready, bus.alu_ready); end
    step_cycle();
    checks++; if (bus.mem_ready !== 1'b1 || bus.write_id !== 5'd11 || bus.write_en !== 1'b1) begin
      failures++; $display("FAIL full_first_pop: got mem_ready=%0b id=%0d en=%0b expected 1/11/1", bus.mem_ready, bus.write_id, bus.write_en); end
    step_cycle();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, AW'(12 + i), 32'hF000_0001 + i}) begin
        failures++; $display("FAIL full_drain[%0d]: got id=%0d data=%0h expected %0d/%0h", i, bus.write_id, bus.write_data, 12 + i, 32'hF000_0001 + i); end
    end
    checks++; if (bus.busy_mask !== '0) begin failures++; $display("FAIL full_busy_clear: got %0h expected 0", bus.busy_mask); end
  endtask

  task automatic test_x0();
    drive_idle();
    bus.alu_valid = 1'b1; bus.alu_id = 5'd0; bus.alu_data = 32'h1111;
    step_cycle();
    drive_idle();
    checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL x0_alu: got write_en %0b expected 0", bus.write_en); end
    issue(5'd0);
    checks++; if (bus.busy_mask !== '0) begin failures++; $display("FAIL x0_issue: got busy %0h expected 0", bus.busy_mask); end
    bus.mem_valid = 1'b1; bus.mem_id = 5'd0; bus.mem_data = 32'h2222;
    step_cycle();
    drive_idle();
    step_cycle();
    checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL x0_load: got write_en %0b expected 0", bus.write_en); end
    // If the id-0 entry had stayed queued the ALU would be starved off within LIMIT cycles.
    bus.alu_valid = 1'b1; bus.alu_id = 5'd1;
    for (int k = 0; k < LIMIT + 2; k++) begin
      bus.alu_data = $urandom;
      #1;
      checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL x0_fifo_popped[%0d]: got alu_ready %0b expected 1", k, bus.alu_ready); end
      step_cycle();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    issue(5'd3);
    issue(5'd9);
    bus.alu_valid = 1'b1; bus.alu_id = 5'd1; bus.alu_data = $urandom;
    bus.mem_valid = 1'b1; bus.mem_id = 5'd3; bus.mem_data = 32'h33; step_cycle();
    bus.mem_id = 5'd9; bus.mem_data = 32'h99; step_cycle();
    bus.mem_id = 5'd0; bus.mem_data = 32'h00; step_cycle();
    bus.mem_valid = 1'b0;
    checks++; if (bus.busy_mask !== 32'h0000_0208) begin failures++; $display("FAIL mid_busy_before: got %0h expected 208", bus.busy_mask); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy_mask !== '0 || bus.write_en !== 1'b0) begin
      failures++; $display("FAIL mid_async_clear: got busy=%0h en=%0b expected 0/0", bus.busy_mask, bus.write_en); end
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      failures++; $display("FAIL mid_async_ready: got mem=%0b alu=%0b expected 1/1", bus.mem_ready, bus.alu_ready); end
    step_cycle();
    step_cycle();
    checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL mid_held: got write_en %0b expected 0", bus.write_en); end
    drive_idle();
    rst = 1'b0;
    step_cycle();
    bus.alu_valid = 1'b1; bus.alu_id = 5'd4; bus.alu_data = 32'h0BAD_CAFE;
    step_cycle();
    checks++; if ({bus.write_en, bus.write_id, bus.write_data} !== {1'b1, 5'd4, 32'h0BAD_CAFE}) begin
      failures++; $display("FAIL mid_alu_after: got en=%0b id=%0d data=%0h expected 1/4/badcafe", bus.write_en, bus.write_id, bus.write_data); end
    for (int k = 0; k < LIMIT + 1; k++) begin
      checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL mid_fifo_empty[%0d]: got alu_ready %0b expected 1", k, bus.alu_ready); end
      step_cycle();
    end
    drive_idle();
    step_cycle();
  endtask

  task automatic test_random();
    logic [AW-1:0] pending[$];
    logic [AW-1:0] id;
    bit            mem_acc;
    for (int n = 0; n < 600; n++) begin
      drive_idle();
      id = AW'($urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 2) == 0 && !(id != 0 && m_busy[id])) begin
        bus.issue_valid = 1'b1; bus.issue_id = id;
      end
      if (pending.size() != 0 && $urandom_range(0, 1) == 1) begin
        bus.mem_valid = 1'b1; bus.mem_id = pending[0]; bus.mem_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.mem_valid = 1'b1; bus.mem_id = '0; bus.mem_data = $urandom;
      end
      id = AW'($urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 9) < 7 && !(id != 0 && m_busy[id])) begin
        bus.alu_valid = 1'b1; bus.alu_id = id; bus.alu_data = $urandom;
      end
      bus.read1_id = AW'($urandom_range(0, NREGS - 1));
      bus.read2_id = AW'($urandom_range(0, NREGS - 1));
      #1;
      checks++; if (bus.alu_ready !== (m_starve != LIMIT)) begin failures++; $display("FAIL rnd_alu_ready[%0d]: got %0b expected %0b", n, bus.alu_ready, m_starve != LIMIT); end
      checks++; if (bus.mem_ready !== (m_fifo.size() < DEPTH)) begin failures++; $display("FAIL rnd_mem_ready[%0d]: got %0b expected %0b", n, bus.mem_ready, m_fifo.size() < DEPTH); end
      checks++; if (bus.busy_mask !== m_busy) begin failures++; $display("FAIL rnd_busy[%0d]: got %0h expected %0h", n, bus.busy_mask, m_busy); end
      checks++; if (bus.hazard !== (m_busy[bus.read1_id] | m_busy[bus.read2_id])) begin failures++; $display("FAIL rnd_hazard[%0d]: got %0b", n, bus.hazard); end
      mem_acc = bus.mem_valid && (m_fifo.size() < DEPTH);
      step_cycle();
      if (mem_acc && bus.mem_id != 0) void'(pending.pop_front());
      if (bus.issue_valid && bus.issue_id != 0) pending.push_back(bus.issue_id);
      checks++; if (bus.write_en !== m_we) begin failures++; $display("FAIL rnd_write_en[%0d]: got %0b expected %0b", n, bus.write_en, m_we); end
      if (m_we) begin
        checks++; if (bus.write_id !== m_wid || bus.write_data !== m_wdata) begin
          failures++; $display("FAIL rnd_write[%0d]: got %0d/%0h expected %0d/%0h", n, bus.write_id, bus.write_data, m_wid, m_wdata); end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_alu_only();
    test_load_round_trip();
    test_starvation();
    test_full_fifo();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back stage that owns the write port of the integer register file. Merges single-cycle ALU results and long-latency load results into one registered write per cycle. Buffers load results in a small FIFO and keeps a pending-write scoreboard that decode checks for RAW hazards. Sits between the execute/memory units and the register file; its `write_en`/`write_id`/`write_data` connect directly to the register file's write port.

## Interface
- `ADDRESS_WIDTH`, 5, register index width; the file has 2^ADDRESS_WIDTH entries.
- `DATA_WIDTH`, 32, register data width.
- `FIFO_DEPTH`, 4, load-result buffer entries; must be a power of two and at least 2.
- `STARVE_LIMIT`, 4, consecutive cycles a non-empty FIFO may lose arbitration before it is forced to win.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high (matches `RESET` in `common`).
- `issue_valid` in 1: decode issues a load whose destination is `issue_id`.
- `issue_id` in ADDRESS_WIDTH: load destination register.
- `alu_valid` in 1: ALU result present.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_id` in ADDRESS_WIDTH: ALU destination.
- `alu_data` in DATA_WIDTH: ALU result.
- `mem_valid` in 1: load result present.
- `mem_ready` out 1: FIFO can accept; equals not-full.
- `mem_id` in ADDRESS_WIDTH: load destination.
- `mem_data` in DATA_WIDTH: load data.
- `read1_id` in ADDRESS_WIDTH: decode source-register index 1 for the hazard check.
- `read2_id` in ADDRESS_WIDTH: decode source-register index 2 for the hazard check.
- `hazard` out 1: combinational; `busy_mask[read1_id] | busy_mask[read2_id]`.
- `busy_mask` out 2^ADDRESS_WIDTH: scoreboard of registers with an outstanding load.
- `write_en` out 1: registered register-file write enable.
- `write_id` out ADDRESS_WIDTH: registered write index.
- `write_data` out DATA_WIDTH: registered write data.

## Operation
- Arbitration, evaluated every cycle:
  - Sources are an ALU transfer (`alu_valid && alu_ready`) and a FIFO pop.
  - The ALU wins by default.
  - The FIFO wins when `starve_cnt == STARVE_LIMIT`. In that cycle `alu_ready` is 0; otherwise `alu_ready` is 1.
  - The FIFO pops when it is non-empty and either the ALU has no transfer or the FIFO is forced.
- Starvation counter `starve_cnt`:
  - Increments when the FIFO is non-empty and does not pop.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- The winner's id and data are registered into `write_id`/`write_data`.
  - `write_en` is 1 if a winner existed and its id is non-zero.
  - Writes to x0 are dropped: `write_en` stays 0, but the FIFO still pops.
- FIFO push occurs on `mem_valid && mem_ready`.
  - A push and a pop in the same cycle are legal when not full.
  - When full, `mem_ready` is 0; there is no pass-through.
- Scoreboard:
  - `issue_valid` with a non-zero `issue_id` sets `busy_mask[issue_id]`.
  - A FIFO pop clears `busy_mask[popped id]` on the same edge that loads the write register.
  - If a set and a clear target the same id in the same cycle, the set wins.
  - Bit 0 is never set.
- Upstream contract (checked by assertions, not handled in RTL):
  - Decode never issues a load to a busy register.
  - The ALU never targets a busy register.
  - Every `mem_valid` corresponds to exactly one prior issue.
- Reset (async assert, any time, including mid-operation):
  - FIFO is flushed and `starve_cnt` is set to 0.
  - `busy_mask` becomes 0.
  - `write_en`, `write_id` and `write_data` become 0; any pending write is lost.
  - While `rst` is high, `alu_ready` and `mem_ready` read 1, but all inputs are ignored.

## Timing
- ALU path: transfer in cycle N → `write_en` high in cycle N+1.
- Load path: accepted in N → earliest pop in N+1 → `write_en` in N+2.
- `busy_mask` bit falls in the same cycle `write_en` rises for that load. The register file's write-through forwarding covers a read of that register in that cycle, so `hazard` may drop then.
- `busy_mask` bit rises in the cycle after `issue_valid`.
- Guaranteed FIFO progress: a non-empty FIFO pops within STARVE_LIMIT+1 cycles.
- `hazard`, `alu_ready` and `mem_ready` are combinational from state and the `read*_id` inputs only. There is no combinational path from `*_valid` to `*_ready`.

## Structure
- `common` package:
  - Existing `RESET` constant.
  - New `wb_src_e` enum {WB_NONE, WB_ALU, WB_MEM} for the arbitration result, which the bench also uses.
- Sub-module `wb_fifo`:
  - Synchronous FIFO, DEPTH × (ADDRESS_WIDTH+DATA_WIDTH).
  - Pointers one bit wider than log2(DEPTH); full/empty from pointer compare.
  - Async active-high reset.
- Top level holds the arbiter, starvation counter, scoreboard and write registers.

## Test plan
- ALU only: `alu_valid`=1 with id 5 and data 0xDEADBEEF at cycle 3 → cycle 4 shows `write_en`=1, `write_id`=5, `write_data`=0xDEADBEEF.
- Load round trip:
  - Stimulus: issue id 7 at cycle 1, then mem result id 7 / 0x1234 at cycle 4, no ALU traffic.
  - Response: `busy_mask[7]`=1 and `hazard`=1 (with `read1_id`=7) from cycle 2; write 0x1234 in cycle 6, with `busy_mask[7]`=0 in cycle 6.
- Starvation:
  - Stimulus: FIFO holds one entry while `alu_valid` is held at 1 continuously.
  - Response: ALU writes for 4 cycles, then `alu_ready`=0 for one cycle and the FIFO entry is written, then the ALU resumes.
- Full FIFO: 4 loads pushed with ALU saturating → `mem_ready`=0 after the 4th push; the 5th `mem_valid` is held and not accepted until the first pop.
- x0 writes:
  - ALU id 0 → `write_en` stays 0.
  - `issue_valid` with id 0 → `busy_mask` unchanged.
  - Load id 0 → FIFO pops, no write.
- Reset mid-operation: assert `rst` asynchronously with 3 FIFO entries and busy bits {3,9} → immediately FIFO empty, `busy_mask`=0, `write_en`=0; normal ALU write succeeds 2 cycles after release.
